// File: rtl/alu_pkg.sv
// Shared definitions for the ALU stage: opcodes, flag bit positions and FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_RLC  = 4'hC;
    localparam logic [3:0] OP_CMP  = 4'hD;
    localparam logic [3:0] OP_MUL  = 4'hE;
    localparam logic [3:0] OP_PASS = 4'hF;

    // Positions inside the {S, Z, P, CY} flag vector
    localparam int FLG_CY = 0;
    localparam int FLG_P  = 1;
    localparam int FLG_Z  = 2;
    localparam int FLG_S  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_unit_if.sv
// Operand/result bundle between the register array side and the ALU stage.
interface alu_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] R0_in;
    logic [WIDTH-1:0] dataBus_in;
    logic             L_T;
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] ALU_out;
    logic [WIDTH-1:0] ALU_hi;
    logic [3:0]       flags;
    logic             busy;
    logic             done;

    // master drives operands and commands, slave is the ALU itself
    modport master (
        output R0_in, dataBus_in, L_T, start, op,
        input  ALU_out, ALU_hi, flags, busy, done
    );

    modport slave (
        input  R0_in, dataBus_in, L_T, start, op,
        output ALU_out, ALU_hi, flags, busy, done
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit consumed per step.
// product is the accumulator value after the current step, so the caller
// can register it on the same edge that last is high.
module mul_seq #(
    parameter int WIDTH = 8,
    parameter int STEPS = WIDTH
) (
    input  logic               clk1,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);
    localparam int CNT_W = $clog2(STEPS) + 1;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;

    assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last    = (cnt_q == CNT_W'(STEPS - 1));

    // Capture operands on load; each step accumulates and shifts both operands
    always_ff @(posedge clk1) begin
        if (load) begin
            mcand_q  <= {{WIDTH{1'b0}}, mcand};
            mplier_q <= mplier;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step) begin
            acc_q    <= product;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/alu_unit.sv
// ALU stage feeding the register array write port: single-cycle ops,
// iterative MUL, temp operand register T and processor flags.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MUL_STEPS = WIDTH
) (
    input logic       clk1,
    input logic       rst,
    alu_unit_if.slave bus
);
    alu_state_t       state_q;
    logic [WIDTH-1:0] t_q;
    logic [WIDTH-1:0] alu_out_q;
    logic [WIDTH-1:0] alu_hi_q;
    logic [3:0]       flags_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0]   sc_res;
    logic               sc_cy;
    logic               sc_wr;
    logic [WIDTH:0]     sum;
    logic               mul_load;
    logic               mul_step;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_last;

    assign bus.ALU_out = alu_out_q;
    assign bus.ALU_hi  = alu_hi_q;
    assign bus.flags   = flags_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r, input logic cy);
        logic [3:0] f;
        f         = '0;
        f[FLG_S]  = r[WIDTH-1];
        f[FLG_Z]  = (r == '0);
        f[FLG_P]  = ~^r;
        f[FLG_CY] = cy;
        return f;
    endfunction

    assign mul_load = (state_q == ST_IDLE) && bus.start && (bus.op == OP_MUL);
    assign mul_step = (state_q == ST_MUL);

    mul_seq #(
        .WIDTH (WIDTH),
        .STEPS (MUL_STEPS)
    ) u_mul (
        .clk1    (clk1),
        .load    (mul_load),
        .step    (mul_step),
        .mcand   (bus.R0_in),
        .mplier  (t_q),
        .product (mul_prod),
        .last    (mul_last)
    );

    // Single-cycle datapath: result, new carry and whether ALU_out is written
    always_comb begin
        logic cy_in;
        cy_in  = flags_q[FLG_CY];
        sum    = '0;
        sc_res = '0;
        sc_cy  = cy_in;
        sc_wr  = 1'b1;
        case (bus.op)
            OP_ADD: begin
                sum    = {1'b0, bus.R0_in} + {1'b0, t_q};
                sc_res = sum[WIDTH-1:0];
                sc_cy  = sum[WIDTH];
            end
            OP_ADC: begin
                sum    = {1'b0, bus.R0_in} + {1'b0, t_q} + {{WIDTH{1'b0}}, cy_in};
                sc_res = sum[WIDTH-1:0];
                sc_cy  = sum[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                sum    = {1'b0, bus.R0_in} - {1'b0, t_q};
                sc_res = sum[WIDTH-1:0];
                sc_cy  = sum[WIDTH];
                sc_wr  = (bus.op != OP_CMP);
            end
            OP_SBB: begin
                sum    = {1'b0, bus.R0_in} - {1'b0, t_q} - {{WIDTH{1'b0}}, cy_in};
                sc_res = sum[WIDTH-1:0];
                sc_cy  = sum[WIDTH];
            end
            OP_AND: begin
                sc_res = bus.R0_in & t_q;
                sc_cy  = 1'b0;
            end
            OP_OR: begin
                sc_res = bus.R0_in | t_q;
                sc_cy  = 1'b0;
            end
            OP_XOR: begin
                sc_res = bus.R0_in ^ t_q;
                sc_cy  = 1'b0;
            end
            OP_NOT:  sc_res = ~bus.R0_in;
            OP_INC:  sc_res = bus.R0_in + WIDTH'(1);
            OP_DEC:  sc_res = bus.R0_in - WIDTH'(1);
            OP_SHL: begin
                sc_res = {bus.R0_in[WIDTH-2:0], 1'b0};
                sc_cy  = bus.R0_in[WIDTH-1];
            end
            OP_SHR: begin
                sc_res = {1'b0, bus.R0_in[WIDTH-1:1]};
                sc_cy  = bus.R0_in[0];
            end
            OP_RLC: begin
                sc_res = {bus.R0_in[WIDTH-2:0], cy_in};
                sc_cy  = bus.R0_in[WIDTH-1];
            end
            OP_PASS: sc_res = t_q;
            default: sc_wr  = 1'b0;
        endcase
    end

    // Control FSM with T register, result/flag registers and done/busy outputs
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            t_q       <= '0;
            alu_out_q <= '0;
            alu_hi_q  <= '0;
            flags_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.L_T) begin
                t_q <= bus.dataBus_in;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MUL) begin
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
                        end else begin
                            if (sc_wr) begin
                                alu_out_q <= sc_res;
                            end
                            alu_hi_q <= '0;
                            flags_q  <= make_flags(sc_res, sc_cy);
                            done_q   <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        alu_out_q <= mul_prod[WIDTH-1:0];
                        alu_hi_q  <= mul_prod[2*WIDTH-1:WIDTH];
                        flags_q   <= make_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH]);
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed scenarios plus random ops
// checked against an arithmetic reference model.
module tb_alu_unit;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    alu_unit_if #(.WIDTH(W)) bus ();

    alu_unit #(.WIDTH(W), .MUL_STEPS(W)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    int n_vec    = 0;
    int n_bad    = 0;
    int n_issued = 0;
    int done_seen = 0;

    // expected {ALU_out, ALU_hi, flags}
    logic [19:0] exp_q[$];
    logic [19:0] e;

    // reference model state
    int m_t  = 0;
    int m_cy = 0;
    int m_out = 0;

    task automatic cmp(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode definitions
    task automatic model_issue(input int op, input int a);
        int r, res, cy, hi, out, ones, p, b;
        logic [3:0] fl;
        b   = m_t;
        cy  = m_cy;
        hi  = 0;
        r   = 0;
        case (op)
            0:  begin r = a + b;        cy = (r > 255); end
            1:  begin r = a + b + m_cy; cy = (r > 255); end
            2:  begin r = a - b;        cy = (r < 0);   end
            3:  begin r = a - b - m_cy; cy = (r < 0);   end
            4:  begin r = a & b;        cy = 0;         end
            5:  begin r = a | b;        cy = 0;         end
            6:  begin r = a ^ b;        cy = 0;         end
            7:  r = 255 - a;
            8:  r = a + 1;
            9:  r = a - 1;
            10: begin r = a * 2;        cy = (a >= 128); end
            11: begin r = a / 2;        cy = a % 2;      end
            12: begin r = a * 2 + m_cy; cy = (a >= 128); end
            13: begin r = a - b;        cy = (r < 0);   end
            14: begin p = a * b; r = p; hi = p / 256; cy = (hi != 0); end
            default: r = b;
        endcase
        res  = r & 255;
        out  = (op == 13) ? m_out : res;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (res >> i) & 1;
        fl[3] = (res >= 128);
        fl[2] = (res == 0);
        fl[1] = (ones % 2 == 0);
        fl[0] = (cy != 0);
        exp_q.push_back({out[7:0], hi[7:0], fl});
        m_cy  = cy;
        m_out = out;
        n_issued++;
    endtask

    // Monitor: every done pulse pops one expected response
    always @(negedge clk1) begin
        if (bus.done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                cmp("ALU_out", int'(bus.ALU_out), int'(e[19:12]));
                cmp("ALU_hi",  int'(bus.ALU_hi),  int'(e[11:4]));
                cmp("flags",   int'(bus.flags),   int'(e[3:0]));
            end
        end
    end

    task automatic set_t(input int v);
        bus.dataBus_in = v[7:0];
        bus.L_T = 1'b1;
        @(posedge clk1);
        #1 bus.L_T = 1'b0;
        m_t = v;
    endtask

    task automatic wait_done(input int budget);
        bit found;
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk1);
            if (bus.done === 1'b1) found = 1'b1;
        end
        if (!found) cmp("done_timeout", 0, 1);
    endtask

    task automatic do_op(input int op, input int a);
        bus.R0_in = a[7:0];
        bus.op    = op[3:0];
        bus.start = 1'b1;
        model_issue(op, a);
        @(posedge clk1);
        #1 bus.start = 1'b0;
        wait_done(20);
    endtask

    initial begin
        int busy_cnt, k_done;
        bit found;
        bus.R0_in = '0;
        bus.dataBus_in = '0;
        bus.L_T = 1'b0;
        bus.start = 1'b0;
        bus.op = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk1);
        #1 rst = 1'b0;
        @(negedge clk1);
        cmp("rst_ALU_out", int'(bus.ALU_out), 0);
        cmp("rst_ALU_hi",  int'(bus.ALU_hi),  0);
        cmp("rst_flags",   int'(bus.flags),   0);
        cmp("rst_busy",    int'(bus.busy),    0);
        cmp("rst_done",    int'(bus.done),    0);

        // ADD with carry-out to zero
        set_t(8'h3C);
        do_op(OP_ADD, 8'hC4);
        cmp("add_out", int'(bus.ALU_out), 8'h00);
        cmp("add_flags", int'(bus.flags), 4'b0111);
        @(negedge clk1);
        cmp("add_done_one_cycle", int'(bus.done), 0);

        // SUB with borrow, then CMP leaves ALU_out alone
        set_t(8'h05);
        do_op(OP_SUB, 8'h03);
        cmp("sub_out", int'(bus.ALU_out), 8'hFE);
        cmp("sub_flags", int'(bus.flags), 4'b1001);
        set_t(8'h03);
        do_op(OP_CMP, 8'h03);
        cmp("cmp_out", int'(bus.ALU_out), 8'hFE);
        cmp("cmp_flags", int'(bus.flags), 4'b0110);

        // MUL 0x20*0x10 with a start issued mid-run
        set_t(8'h10);
        bus.R0_in = 8'h20;
        bus.op = OP_MUL;
        bus.start = 1'b1;
        model_issue(14, 8'h20);
        @(posedge clk1);
        #1 bus.start = 1'b0;
        busy_cnt = 0;
        k_done = -1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk1);
            if (bus.done === 1'b1) begin
                found = 1'b1;
                k_done = k;
            end else begin
                if (bus.busy === 1'b1) busy_cnt++;
                if (k == 2) begin
                    bus.op = OP_ADD;
                    bus.start = 1'b1;
                end
                if (k == 3) bus.start = 1'b0;
            end
        end
        cmp("mul_busy_cycles", busy_cnt, 8);
        cmp("mul_done_latency", k_done, 8);
        cmp("mul_out", int'(bus.ALU_out), 8'h00);
        cmp("mul_hi", int'(bus.ALU_hi), 8'h02);
        cmp("mul_flags", int'(bus.flags), 4'b0111);
        @(negedge clk1);
        cmp("mul_busy_after", int'(bus.busy), 0);

        // Reset during the 4th MUL iteration discards everything
        set_t(8'h0F);
        bus.R0_in = 8'h0F;
        bus.op = OP_MUL;
        bus.start = 1'b1;
        @(posedge clk1);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk1);
        #1 rst = 1'b1;
        @(posedge clk1);
        #1 rst = 1'b0;
        m_t = 0;
        m_cy = 0;
        m_out = 0;
        @(negedge clk1);
        cmp("mrst_ALU_out", int'(bus.ALU_out), 0);
        cmp("mrst_ALU_hi",  int'(bus.ALU_hi),  0);
        cmp("mrst_flags",   int'(bus.flags),   0);
        cmp("mrst_busy",    int'(bus.busy),    0);
        cmp("mrst_done",    int'(bus.done),    0);
        repeat (12) @(negedge clk1);
        set_t(8'h01);
        do_op(OP_ADD, 8'h01);
        cmp("post_rst_add", int'(bus.ALU_out), 8'h02);

        // Carry in for RLC, then INC wrap keeps CY
        do_op(OP_ADD, 8'hFF);
        do_op(OP_RLC, 8'h80);
        cmp("rlc_out", int'(bus.ALU_out), 8'h01);
        cmp("rlc_flags", int'(bus.flags), 4'b0001);
        do_op(OP_INC, 8'hFF);
        cmp("inc_out", int'(bus.ALU_out), 8'h00);
        cmp("inc_flags", int'(bus.flags), 4'b0111);

        // L_T and start on the same edge: op sees the old T
        set_t(8'h55);
        bus.dataBus_in = 8'hAA;
        bus.L_T = 1'b1;
        bus.R0_in = 8'h00;
        bus.op = OP_PASS;
        bus.start = 1'b1;
        model_issue(15, 0);
        @(posedge clk1);
        #1 begin
            bus.L_T = 1'b0;
            bus.start = 1'b0;
        end
        m_t = 8'hAA;
        wait_done(20);
        cmp("pass_old_t", int'(bus.ALU_out), 8'h55);
        do_op(OP_PASS, 0);
        cmp("pass_new_t", int'(bus.ALU_out), 8'hAA);
        cmp("pass_flags", int'(bus.flags), 4'b1011);

        // Random ops, occasional T reloads
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) set_t(int'($urandom_range(0, 255)));
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clk1);
        cmp("pending_left", exp_q.size(), 0);
        cmp("done_count", done_seen, n_issued);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
